// File: rtl/video_timing_pkg.sv
// Shared definitions for the video scanout block.
// Holds the default 800x480 raster timing, the pixel type, default counter
// widths and a helper that sizes a counter for a given period.
package video_timing_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 13;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 29;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int RGB_W          = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  // Width able to hold every value 0..total (total itself is used as an
  // exclusive upper bound in range compares, so it must fit too).
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

  localparam int H_CNT_W = cnt_width(H_TOTAL_DEF);
  localparam int V_CNT_W = cnt_width(V_TOTAL_DEF);

endpackage

// File: rtl/video_scanout_if.sv
// Pixel-source link of the scanout.
// Signals:
//   in_pixel_data  : pixel from the source
//   in_pixel_valid : data valid, one cycle after a request
//   in_pixel_ready : request for exactly one pixel
//   out_next_frame : one-cycle pulse restarting the source at (0,0)
// Modports:
//   master : the scanout, which owns flow control (drives ready / next_frame)
//   slave  : the pixel source
interface video_scanout_if;
  import video_timing_pkg::*;

  rgb_t in_pixel_data;
  logic in_pixel_valid;
  logic in_pixel_ready;
  logic out_next_frame;

  modport master (
    input  in_pixel_data,
    input  in_pixel_valid,
    output in_pixel_ready,
    output out_next_frame
  );

  modport slave (
    output in_pixel_data,
    output in_pixel_valid,
    input  in_pixel_ready,
    input  out_next_frame
  );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous show-ahead FIFO for pixels.
// Ports:
//   clk, srst    : clock, synchronous active-high reset
//   flush_i      : empties the FIFO on the next edge (wins over push/pop)
//   push_i       : write push_data_i; dropped when full
//   pop_i        : consume the head; ignored when empty
//   pop_data_o   : current head (valid while !empty_o)
//   count_o      : number of stored entries
//   empty_o      : no entries
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       pop_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  // Full check uses the registered count, so a push into a full FIFO is
  // dropped even if a pop happens in the same cycle.
  assign do_push    = push_i && (count_q != DEPTH_C);
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/video_scanout.sv
// Display scanout: buffers pixels from the source, generates raster timing
// and drives RGB / hsync / vsync / data-enable to the PHY.
// Ports:
//   in_clk, in_reset  : pixel clock, synchronous active-high reset
//   pix (master)      : pixel-source link (data/valid in, ready/next_frame out)
//   out_rgb           : pixel to PHY, 0 outside the active region or on underflow
//   out_hsync/out_vsync/out_de : registered, aligned with out_rgb
//   out_underflow_count : saturating underflow-cycle counter, present only
//                         when VIDEO_SCANOUT_UNDERFLOW_COUNT_EN is defined
// Counters restart at the frame point F (h==0, first vsync line), where the
// source is told to restart and the FIFO is flushed so every frame starts
// pixel-aligned even after an underflow.
module video_scanout
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic HSYNC_POL  = 1'b0,
  parameter logic VSYNC_POL  = 1'b0,
  parameter int   FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic            in_clk,
  input  logic            in_reset,
  video_scanout_if.master pix,
  output rgb_t            out_rgb,
  output logic            out_hsync,
  output logic            out_vsync,
  output logic            out_de
`ifdef VIDEO_SCANOUT_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]     out_underflow_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL == H_TOTAL_DEF) ? H_CNT_W : cnt_width(H_TOTAL);
  localparam int VW = (V_TOTAL == V_TOTAL_DEF) ? V_CNT_W : cnt_width(V_TOTAL);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_ACT_C      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS_START_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS_END_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_C     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_START_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C     = VW'(V_TOTAL - 1);
  localparam logic [CW:0]   DEPTH_C      = (CW+1)'(FIFO_DEPTH);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          inflight_q;
  rgb_t          rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;

  logic          active, at_f, blackout, ready;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   level;
  logic          fifo_empty;
  rgb_t          fifo_data;

  assign active = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign at_f   = (h_q == '0) && (v_q == V_VS_START_C);
  // No requests from the start of the vertical front porch through F, so no
  // pixel can land after the flush and misalign the next frame.
  assign blackout = ((v_q >= V_ACT_C) && (v_q < V_VS_START_C)) || at_f;
  // Reserve room for the pixel requested last cycle that may still arrive.
  assign level  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign ready  = (level < DEPTH_C) && !blackout && !in_reset;

  assign pix.in_pixel_ready = ready;
  assign pix.out_next_frame = at_f && !in_reset;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RGB_W)
  ) u_fifo (
    .clk         (in_clk),
    .srst        (in_reset),
    .flush_i     (at_f),
    .push_i      (pix.in_pixel_valid),
    .push_data_i (pix.in_pixel_data),
    .pop_i       (active),
    .pop_data_o  (fifo_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == H_LAST_C) begin
      h_d = '0;
      v_d = (v_q == V_LAST_C) ? '0 : v_q + VW'(1);
    end
    rgb_d   = (active && !fifo_empty) ? fifo_data : '0;
    de_d    = active;
    hsync_d = ((h_q >= H_HS_START_C) && (h_q < H_HS_END_C)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((v_q >= V_VS_START_C) && (v_q < V_VS_END_C)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      h_q        <= '0;
      v_q        <= V_VS_START_C;
      inflight_q <= 1'b0;
      rgb_q      <= '0;
      de_q       <= 1'b0;
      hsync_q    <= ~HSYNC_POL;
      vsync_q    <= ~VSYNC_POL;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      inflight_q <= ready;
      rgb_q      <= rgb_d;
      de_q       <= de_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign out_rgb   = rgb_q;
  assign out_de    = de_q;
  assign out_hsync = hsync_q;
  assign out_vsync = vsync_q;

`ifdef VIDEO_SCANOUT_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_q, underflow_d;

  always_comb begin
    underflow_d = underflow_q;
    if (active && fifo_empty && (underflow_q != 16'hFFFF)) underflow_d = underflow_q + 16'd1;
  end

  always_ff @(posedge in_clk) begin
    if (in_reset) underflow_q <= '0;
    else          underflow_q <= underflow_d;
  end

  assign out_underflow_count = underflow_q;
`endif

endmodule

// File: tb/tb_video_scanout.sv
// Randomized scoreboard bench for video_scanout on a shrunken raster.
// The driver runs a behavioural model (raster position from elapsed cycles,
// FIFO as a queue) and pushes expectations; a monitor pops and compares.
module tb_video_scanout;
  import video_timing_pkg::*;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 6;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VA = 8, VFP = 2, VSW = 2, VBP = 4;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int DEPTH = 16;
  localparam int NUM_FRAMES = 8;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  video_scanout_if pix_if();
  rgb_t out_rgb;
  logic out_hsync, out_vsync, out_de;
`ifdef VIDEO_SCANOUT_UNDERFLOW_COUNT_EN
  logic [15:0] out_underflow_count;
`endif

  video_scanout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
    .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .FIFO_DEPTH (DEPTH)
  ) dut (
    .in_clk    (clk),
    .in_reset  (rst),
    .pix       (pix_if),
    .out_rgb   (out_rgb),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_de    (out_de)
`ifdef VIDEO_SCANOUT_UNDERFLOW_COUNT_EN
    ,
    .out_underflow_count (out_underflow_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic ready; logic nf; } ctrl_t;
  typedef struct { bit en; logic de; rgb_t rgb; logic hs; logic vs; logic [15:0] ucnt; } vid_t;

  ctrl_t cq[$];
  vid_t  vq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Source test pattern: {x[9:8] x4, y[7:0], x[7:0]}.
  function automatic rgb_t pattern(input int pos);
    logic [9:0] x;
    logic [7:0] y;
    x = 10'(pos % HA);
    y = 8'(pos / HA);
    return {{4{x[9:8]}}, y, x[7:0]};
  endfunction

  // Driver + reference model.
  initial begin : driver
    rgb_t  mq[$];
    int    t, srcpos, fr, uf, k, h, vv, size0;
    bit    infl, req_prev, reset_done, do_rst, at_f, active, blackout;
    bit    exp_ready, stall, valid;
    rgb_t  data, exp_rgb;
    ctrl_t ci;
    vid_t  vi;

    t = 0; srcpos = 0; fr = 0; uf = 0; k = 0;
    infl = 0; req_prev = 0; reset_done = 0;
    pix_if.in_pixel_valid = 1'b0;
    pix_if.in_pixel_data  = '0;
    vi.en = 1'b0; vi.de = 1'b0; vi.rgb = '0; vi.hs = 1'b0; vi.vs = 1'b0; vi.ucnt = '0;
    vq.push_back(vi);  // outputs before the first reset edge are unknown

    while (fr <= NUM_FRAMES && k < 20 * FRAME) begin
      @(posedge clk);
      #1;
      cyc++;
      h  = t % HT;
      vv = (VA + VFP + t / HT) % VT;
      do_rst = (k < 3);
      if (!do_rst && !reset_done && fr == 2 && h == HA / 2 && vv == VA / 2) begin
        do_rst = 1'b1;
        reset_done = 1'b1;
      end
      rst = do_rst;

      if (do_rst) begin
        // A pixel requested last cycle still shows up and must be discarded.
        pix_if.in_pixel_valid = req_prev;
        pix_if.in_pixel_data  = rgb_t'($urandom);
        ci.ready = 1'b0; ci.nf = 1'b0;
        cq.push_back(ci);
        vi.en = 1'b1; vi.de = 1'b0; vi.rgb = '0; vi.hs = !HPOL; vi.vs = !VPOL; vi.ucnt = '0;
        vq.push_back(vi);
        mq.delete();
        t = 0; infl = 0; req_prev = 0; srcpos = 0; uf = 0;
      end else begin
        at_f = ((t % FRAME) == 0);
        if (at_f) begin
          fr++;
          srcpos = 0;
        end
        active    = (h < HA) && (vv < VA);
        blackout  = (vv >= VA && vv < VA + VFP) || at_f;
        exp_ready = !blackout && (mq.size() + int'(infl) < DEPTH);
        ci.ready = exp_ready; ci.nf = at_f;
        cq.push_back(ci);

        stall = (fr == 3 && vv >= 2 && vv < 4) ||
                (fr >= 5 && fr <= 6 && $urandom_range(0, 7) == 0);
        valid = req_prev && !stall;
        if (valid) begin
          data = (fr <= 3) ? pattern(srcpos) : rgb_t'($urandom);
          srcpos++;
        end else begin
          data = rgb_t'($urandom);
        end
        pix_if.in_pixel_valid = valid;
        pix_if.in_pixel_data  = data;

        size0 = mq.size();
        exp_rgb = '0;
        if (active) begin
          if (size0 > 0) exp_rgb = mq.pop_front();
          else if (uf < 65535) uf++;
        end
        if (valid && size0 < DEPTH) mq.push_back(data);
        if (at_f) mq.delete();

        vi.en   = 1'b1;
        vi.de   = active;
        vi.rgb  = exp_rgb;
        vi.hs   = (h >= HA + HFP && h < HA + HFP + HSW) ? HPOL : !HPOL;
        vi.vs   = (vv >= VA + VFP && vv < VA + VFP + VSW) ? VPOL : !VPOL;
        vi.ucnt = 16'(uf);
        vq.push_back(vi);

        infl = exp_ready;
        req_prev = exp_ready;
        t++;
      end
      k++;
    end

    @(posedge clk);
    #1;
    pix_if.in_pixel_valid = 1'b0;
    done = 1'b1;
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: one control expectation per cycle, video expectations one cycle late.
  initial begin : monitor
    ctrl_t c;
    vid_t  v;
    int    frames_seen;
    frames_seen = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!done) begin
        if (cq.size() == 0 || vq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underrun cycle %0d: got %0d/%0d entries expected >0", cyc, cq.size(), vq.size());
        end else begin
          c = cq.pop_front();
          v = vq.pop_front();
          chk("pixel_ready", 32'(pix_if.in_pixel_ready), 32'(c.ready));
          chk("next_frame", 32'(pix_if.out_next_frame), 32'(c.nf));
          if (c.nf) begin
            frames_seen++;
            $display("frame %0d start at cycle %0d, checks so far %0d", frames_seen, cyc, checks);
          end
          if (v.en) begin
            chk("de", 32'(out_de), 32'(v.de));
            chk("rgb", 32'(out_rgb), 32'(v.rgb));
            chk("hsync", 32'(out_hsync), 32'(v.hs));
            chk("vsync", 32'(out_vsync), 32'(v.vs));
`ifdef VIDEO_SCANOUT_UNDERFLOW_COUNT_EN
            chk("underflow_count", 32'(out_underflow_count), 32'(v.ucnt));
`endif
          end
        end
      end
    end
  end

endmodule
